// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, FSM encoding and queue entry layout for the instruction-fetch front end.
package if_fetch_unit_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'hE000_0000;
   localparam logic [31:0] PC_INC    = 32'd4;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc_next;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry FIFO with flush; push visible at the head the cycle after it is written.
// No internal backpressure: the producer must not push into a full queue unless it also pops.
module if_fetch_queue #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_dat,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]       count_q, count_d;
   logic             pop_eff;

   assign pop_eff  = pop && (count_q != 2'd0);
   assign head_dat = ent0_q;
   assign count    = count_q;

   // ent0 is always the head; a pop shifts ent1 down.
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop_eff})
            2'b01: begin
               ent0_d  = ent1_q;
               count_d = count_q - 2'd1;
            end
            2'b10: begin
               if (count_q == 2'd0) ent0_d = push_dat;
               else                 ent1_d = push_dat;
               count_d = count_q + 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  ent0_d = push_dat;
               end else begin
                  ent0_d = ent1_q;
                  ent1_d = push_dat;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC, fetches over req/ready, buffers up to two words for IF/ID.
// One word per cycle on zero-wait memory; freeze with a full queue stalls new requests.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = if_fetch_unit_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR,
   parameter logic [31:0] PC_INC    = if_fetch_unit_pkg::PC_INC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic        fetch_valid
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d, req_addr_q, req_addr_d;
   logic [1:0]   count;
   logic [63:0]  head_dat;
   fetch_entry_t head, push_ent;
   logic         push, drain, space_ok;

   assign head        = fetch_entry_t'(head_dat);
   assign fetch_valid = (count != 2'd0);
   assign drain       = fetch_valid && !freeze;
   assign space_ok    = !((count == 2'd2) && freeze);

   assign pc_out          = fetch_valid ? head.pc_next : 32'h0;
   assign instruction_out = fetch_valid ? head.instr   : NOP_INSTR;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         req_addr_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   // A redirect during an outstanding request must still absorb that response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:     if (!branch_taken && mem_req && !mem_ready) state_d = ST_WAIT;
         ST_WAIT:    if (mem_ready)         state_d = ST_RUN;
                     else if (branch_taken) state_d = ST_DISCARD;
         ST_DISCARD: if (mem_ready)         state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      mem_addr = req_addr_q;
      push     = 1'b0;
      push_ent = '0;
      case (state_q)
         ST_RUN: begin
            mem_req  = space_ok && !branch_taken;
            mem_addr = pc_q;
            push     = mem_req && mem_ready;
            push_ent = '{pc_next: pc_q + PC_INC, instr: mem_rdata};
         end
         ST_WAIT: begin
            mem_req  = 1'b1;
            push     = mem_ready && !branch_taken;
            push_ent = '{pc_next: req_addr_q + PC_INC, instr: mem_rdata};
         end
         ST_DISCARD: mem_req = 1'b1;
         default: ;
      endcase
      if (rst) mem_req = 1'b0;
   end

   always_comb begin
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      if (branch_taken) begin
         pc_d = branch_addr;
      end else if ((state_q == ST_RUN) && mem_req) begin
         pc_d = pc_q + PC_INC;
         if (!mem_ready) req_addr_d = pc_q;
      end
   end

   if_fetch_queue #(.WIDTH(64)) u_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_ent),
      .pop      (drain),
      .flush    (branch_taken),
      .head_dat (head_dat),
      .count    (count)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and random fetch traffic against a queue-based reference model of the fetch unit.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, branch_taken, mem_ready;
   logic [31:0] branch_addr, mem_rdata;
   logic        mem_req, fetch_valid;
   logic [31:0] mem_addr, pc_out, instruction_out;

   int checks = 0;
   int errors = 0;

   // reference model: delivered-but-unconsumed words, PC, one outstanding request
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic        m_out;
   logic [31:0] m_out_addr;
   logic        m_disc;

   if_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ready       (mem_ready),
      .mem_rdata       (mem_rdata),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .fetch_valid     (fetch_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 32'h0;
      m_out  = 1'b0;
      m_disc = 1'b0;
   endtask

   task automatic check_reset_values();
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_instr", instruction_out, 32'hE000_0000);
   endtask

   // Called at a negedge; applies inputs, checks, advances the model, returns at the next negedge.
   task automatic step(input logic fz, input logic br, input logic [31:0] ba, input logic rdy);
      logic        e_req;
      logic [31:0] e_addr;
      freeze       = fz;
      branch_taken = br;
      branch_addr  = ba;
      mem_ready    = rdy;
      #1;
      mem_rdata = memf(mem_addr);
      #1;
      e_req  = m_out || (!(mq.size() == 2 && fz) && !br);
      e_addr = m_out ? m_out_addr : m_pc;
      chk("mem_req", {31'h0, mem_req}, {31'h0, e_req});
      if (e_req) chk("mem_addr", mem_addr, e_addr);
      chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, (mq.size() != 0)});
      chk("pc_out", pc_out, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
      chk("instruction_out", instruction_out, (mq.size() != 0) ? mq[0][31:0] : 32'hE000_0000);
      if (br) begin
         mq.delete();
         if (m_out && !rdy) m_disc = 1'b1;
         else               m_out  = 1'b0;
         m_pc = ba;
      end else begin
         if (mq.size() != 0 && !fz) void'(mq.pop_front());
         if (m_out) begin
            if (rdy) begin
               if (!m_disc) mq.push_back({m_out_addr + 32'd4, memf(m_out_addr)});
               m_out = 1'b0;
            end
         end else if (e_req) begin
            if (rdy) begin
               mq.push_back({m_pc + 32'd4, memf(m_pc)});
            end else begin
               m_out      = 1'b1;
               m_out_addr = m_pc;
               m_disc     = 1'b0;
            end
            m_pc = m_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic async_reset();
      #3;
      rst = 1'b1;
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst          = 1'b1;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 32'h0;
      mem_ready    = 1'b0;
      mem_rdata    = 32'h0;
      model_reset();
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;

      // zero-wait streaming
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // wait states on a fetch, queue drains to bubbles meanwhile
      async_reset();
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // freeze fills the queue and stalls requests, then drains in order
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // redirect while waiting on 0x20
      async_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h100, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // redirect with freeze on a full queue
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h200, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // address wrap, then async reset while waiting
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      async_reset();

      // random traffic
      for (int i = 0; i < 500; i++) begin
         logic        fz, br, rdy;
         logic [31:0] ba;
         fz  = ($urandom_range(0, 9) < 3);
         br  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         ba  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFF4;
         step(fz, br, ba, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
